// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
// Defining MULDIV_MADD_EN adds MADD/MADDU, accumulating the product into {hi,lo}.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [2*WIDTH-1:0] prod, prod_n, res, fin;
   logic [WIDTH-1:0] mcand, ma, mb, q, r;
   logic [WIDTH:0] sum, t, d;
   logic is_div, neg_q, neg_r, sgn, sa, sb, op_mul, op_div;
`ifdef MULDIV_MADD_EN
   logic acc;
`endif
   always_comb begin
      sgn = ~op[0];
`ifdef MULDIV_MADD_EN
      op_mul = op[2:1] == 2'b00 || op[2:1] == 2'b11;
`else
      op_mul = op[2:1] == 2'b00;
`endif
      op_div = op[2:1] == 2'b01;
      sa = sgn & A[WIDTH-1];
      sb = sgn & B[WIDTH-1];
      ma = sa ? -A : A;
      mb = sb ? -B : B;
      // multiply: prod = {partial, multiplier}; divide: prod = {remainder, dividend/quotient}
      sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      t = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
      d = t - {1'b0, mcand};
      prod_n = !is_div ? {sum, prod[WIDTH-1:1]}
             : d[WIDTH] ? {t[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
             : {d[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
      // a zero divisor leaves |A| in the remainder, so the sign fix alone restores hi = A
      q = mcand == '0 ? {WIDTH{1'b1}} : neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
      r = neg_r ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
      res = is_div ? {r, q} : neg_q ? -prod : prod;
`ifdef MULDIV_MADD_EN
      fin = acc ? {hi, lo} + res : res;
`else
      fin = res;
`endif
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         prod <= '0;
         mcand <= '0;
         is_div <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         dz <= 1'b0;
         hi <= '0;
         lo <= '0;
`ifdef MULDIV_MADD_EN
         acc <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               if (op == 3'b100) hi <= A;
               if (op == 3'b101) lo <= A;
               if (op_mul || op_div) begin
                  state <= CALC;
                  busy <= 1'b1;
                  cnt <= '0;
                  is_div <= op_div;
                  mcand <= op_div ? mb : ma;
                  prod <= {{WIDTH{1'b0}}, op_div ? ma : mb};
                  neg_q <= sa ^ sb;
                  neg_r <= sa;
                  if (op_div) dz <= 1'b0;
`ifdef MULDIV_MADD_EN
                  acc <= op[2];
`endif
               end
            end
            CALC: begin
               prod <= prod_n;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) state <= FIN;
            end
            default: begin
               {hi, lo} <= fin;
               done <= 1'b1;
               busy <= 1'b0;
               state <= IDLE;
               if (is_div) dz <= mcand == '0;
            end
         endcase
      end
   end
endmodule
